// File: rtl/gpio_edge_capture_pkg.sv
// Shared constants for the GPIO input conditioning / edge-capture path.
package gpio_edge_capture_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_WIDTH   = 8;

    // Arming spans the synchroniser depth plus one edge so filtered is seeded from a
    // pipeline that has been fully refilled from the pins.
    function automatic int unsigned arm_cycles(int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

    localparam int unsigned ARM_CYCLES = arm_cycles(DEF_SYNC_STAGES);

endpackage

// File: rtl/gpio_debounce_channel.sv
// Single GPIO channel: pin synchroniser, stability counter, filtered level and
// unqualified rise/fall events that take effect on the next clock edge.
module gpio_debounce_channel
    import gpio_edge_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 arming,
    input  logic [CNT_WIDTH-1:0] debounce_limit,
    output logic                 filtered,
    output logic                 rise,
    output logic                 fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filtered_q, filtered_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sync;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign filtered = filtered_q;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in};
        filtered_d = filtered_q;
        cnt_d      = cnt_q;
        rise       = 1'b0;
        fall       = 1'b0;
        if (arming) begin
            filtered_d = sync;
            cnt_d      = '0;
        end else if (sync == filtered_q) begin
            cnt_d = '0;
        end else if (cnt_q >= debounce_limit) begin
            // >= lets a lowered limit accept immediately; counter never passes the limit
            filtered_d = sync;
            cnt_d      = '0;
            rise       = sync;
            fall       = ~sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            filtered_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            filtered_q <= filtered_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_edge_capture.sv
// Per-channel debounce and edge capture with sticky pending flags and a maskable irq.
// Channels are conditioned in gpio_debounce_channel; arming, pending and irq live here.
module gpio_edge_capture
    import gpio_edge_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [WIDTH-1:0]     rising_edge,
    input  logic [WIDTH-1:0]     falling_edge,
    input  logic [CNT_WIDTH-1:0] debounce_limit,
    input  logic [WIDTH-1:0]     clear,
    input  logic [WIDTH-1:0]     irq_enable,
    output logic [WIDTH-1:0]     filtered,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq
);

    localparam int unsigned ArmCycles = arm_cycles(SYNC_STAGES);
    localparam int unsigned ArmWidth  = $clog2(ArmCycles + 1);

    logic [ArmWidth-1:0] arm_q, arm_d;
    logic [WIDTH-1:0]    edge_pulse_q, edge_pulse_d;
    logic [WIDTH-1:0]    pending_q, pending_d;
    logic [WIDTH-1:0]    rise, fall, event_hit;
    logic                arming;

    assign arming = (arm_q != '0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        gpio_debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .in             (in[i]),
            .arming         (arming),
            .debounce_limit (debounce_limit),
            .filtered       (filtered[i]),
            .rise           (rise[i]),
            .fall           (fall[i])
        );
    end

    always_comb begin
        arm_d        = arming ? arm_q - 1'b1 : arm_q;
        event_hit    = (rise & rising_edge) | (fall & falling_edge);
        edge_pulse_d = event_hit;
        // A new event wins over a clear landing on the same edge
        pending_d    = (pending_q & ~clear) | event_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_q        <= ArmWidth'(ArmCycles);
            edge_pulse_q <= '0;
            pending_q    <= '0;
        end else begin
            arm_q        <= arm_d;
            edge_pulse_q <= edge_pulse_d;
            pending_q    <= pending_d;
        end
    end

    assign edge_pulse = edge_pulse_q;
    assign pending    = pending_q;
    assign irq        = |(pending_q & irq_enable);

endmodule
